a_rf_sequencer: RTL and testbench

//  Controller for the 8-entry A-operand register file (shift-loaded RF feeding A_MULT).

---
 rtl/a_rf_seq_pkg.sv | 29 ++
 rtl/a_rf_seq_if.sv | 50 +++++
 rtl/a_rf_seq_cfg_chk.sv | 19 +
 rtl/a_rf_sequencer.sv | 159 +++++++++++++++
 tb/tb_a_rf_sequencer.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/a_rf_seq_pkg.sv
// Shared types and sizes for the A-operand RF sequencer.
// State enum, RF geometry, job length limits, start-address helper.
package a_rf_seq_pkg;

  localparam int RF_DEPTH = 8;
  localparam int ADDR_W   = $clog2(RF_DEPTH);
  localparam int MAX_LEN  = 8;
  localparam int LEN_W    = 4;
  localparam int STAT_W   = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    READ = 2'd2,
    DONE = 2'd3
  } state_e;

  // First read address of a pass: the oldest word
  // (dual read: the oldest pair, low half at r).
  function automatic logic [ADDR_W-1:0] start_addr(
    input logic [LEN_W-1:0] len,
    input logic             mdr
  );
    logic [LEN_W-1:0] t;
    t = len - (mdr ? LEN_W'(2) : LEN_W'(1));
    return t[ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/a_rf_seq_if.sv
// Handshake/control bundle between the job source, the A stream,
// the RF control pins and the multiplier (master drives jobs, slave = sequencer).
interface a_rf_seq_if #(
  parameter int PASS_W = 8
);
  import a_rf_seq_pkg::*;

  logic              start;
  logic              abort;
  logic [LEN_W-1:0]  cfg_len;
  logic [PASS_W-1:0] cfg_passes;
  logic              cfg_mdr;
  logic              ext_cea1;
  logic              ext_cea2;
  logic              a_valid;
  logic              a_ready;
  logic              CEA1;
  logic              CEA2;
  logic              RF_load;
  logic              MDRr;
  logic [ADDR_W-1:0] r_addr;
  logic              mult_valid;
  logic              mult_ready;
  logic              busy;
  logic              done;
  logic              cfg_err;

  modport master (
    output start, abort,
    output cfg_len, cfg_passes, cfg_mdr,
    output ext_cea1, ext_cea2,
    output a_valid, mult_ready,
    input  a_ready, CEA1, CEA2,
    input  RF_load, MDRr, r_addr,
    input  mult_valid, busy, done,
    input  cfg_err
  );

  modport slave (
    input  start, abort,
    input  cfg_len, cfg_passes, cfg_mdr,
    input  ext_cea1, ext_cea2,
    input  a_valid, mult_ready,
    output a_ready, CEA1, CEA2,
    output RF_load, MDRr, r_addr,
    output mult_valid, busy, done,
    output cfg_err
  );

endinterface

// File: rtl/a_rf_seq_cfg_chk.sv
// Job legality check: len in 1..MAX_LEN, and even when dual read.
// Ports: len, mdr in; legal out (combinational).
module a_rf_seq_cfg_chk
  import a_rf_seq_pkg::*;
(
  input  logic [LEN_W-1:0] len,
  input  logic             mdr,
  output logic             legal
);

  logic len_ok;
  logic pair_ok;

  assign len_ok  = (len != '0) &&
                   (len <= LEN_W'(MAX_LEN));
  assign pair_ok = !(mdr && len[0]);
  assign legal   = len_ok && pair_ok;

endmodule

// File: rtl/a_rf_sequencer.sv
// Controller for the 8-entry shift-loaded A RF: loads a job, replays it
// oldest-first for N passes. Ports: CLK, RSTA (async, high), bus (slave);
// stat_stall_cycles / stat_load_wait only when A_RF_SEQ_STATS_EN is defined.
module a_rf_sequencer
  import a_rf_seq_pkg::*;
#(
  parameter int PASS_W = 8
) (
  input  logic             CLK,
  input  logic             RSTA,
  a_rf_seq_if.slave        bus
`ifdef A_RF_SEQ_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_stall_cycles,
  output logic [STAT_W-1:0] stat_load_wait
`endif
);

  state_e            state_q;
  state_e            state_d;

  logic [LEN_W-1:0]  len_q;
  logic [PASS_W-1:0] passes_q;
  logic [PASS_W-1:0] pass_cnt;
  logic [LEN_W-1:0]  load_cnt;
  logic              mdr_q;
  logic [ADDR_W-1:0] raddr_q;
  logic              err_q;

  logic              cfg_ok;
  logic              in_idle;
  logic              in_load;
  logic              in_read;
  logic              take_job;
  logic              bad_job;
  logic              a_rdy;
  logic              accept;
  logic              beat;
  logic              last_word;
  logic              pass_end;
  logic              last_pass;
  logic [ADDR_W-1:0] first_addr;
  logic [ADDR_W-1:0] step;

  a_rf_seq_cfg_chk u_cfg_chk (
    .len   (bus.cfg_len),
    .mdr   (bus.cfg_mdr),
    .legal (cfg_ok)
  );

  assign in_idle = (state_q == IDLE);
  assign in_load = (state_q == LOAD);
  assign in_read = (state_q == READ);

  // abort wins over a start seen in the same cycle
  assign take_job = in_idle && bus.start &&
                    !bus.abort && cfg_ok;
  assign bad_job  = in_idle && bus.start &&
                    !bus.abort && !cfg_ok;

  // no word is taken in an aborting cycle, so the
  // RF never sees a half-accounted load
  assign a_rdy  = in_load && !bus.abort;
  assign accept = a_rdy && bus.a_valid;
  assign beat   = in_read && bus.mult_ready;

  assign last_word = accept &&
    (load_cnt == len_q - LEN_W'(1));
  assign pass_end  = beat && (raddr_q == '0);
  assign last_pass = (pass_cnt ==
    passes_q - PASS_W'(1));

  assign first_addr = start_addr(len_q, mdr_q);
  assign step = mdr_q ? ADDR_W'(2) : ADDR_W'(1);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (take_job) state_d = LOAD;
      LOAD: if (last_word) state_d = READ;
      READ: if (pass_end && last_pass)
              state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.abort) state_d = IDLE;
  end

  always_ff @(posedge CLK or posedge RSTA) begin
    if (RSTA) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge CLK or posedge RSTA) begin
    if (RSTA) begin
      len_q    <= '0;
      passes_q <= '0;
      pass_cnt <= '0;
      load_cnt <= '0;
      mdr_q    <= 1'b0;
      raddr_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= bad_job;
      if (take_job) begin
        len_q    <= bus.cfg_len;
        passes_q <= (bus.cfg_passes == '0) ?
                    PASS_W'(1) : bus.cfg_passes;
        mdr_q    <= bus.cfg_mdr;
        load_cnt <= '0;
        pass_cnt <= '0;
      end else if (accept) begin
        load_cnt <= load_cnt + LEN_W'(1);
        if (last_word) raddr_q <= first_addr;
      end else if (beat) begin
        if (raddr_q != '0) begin
          raddr_q <= raddr_q - step;
        end else if (!last_pass) begin
          // next pass follows with no bubble
          raddr_q  <= first_addr;
          pass_cnt <= pass_cnt + PASS_W'(1);
        end
      end
    end
  end

  assign bus.a_ready    = a_rdy;
  assign bus.RF_load    = accept;
  assign bus.CEA1       = in_idle && bus.ext_cea1;
  assign bus.CEA2       = in_idle && bus.ext_cea2;
  assign bus.MDRr       = mdr_q;
  assign bus.r_addr     = raddr_q;
  assign bus.mult_valid = in_read;
  assign bus.busy       = !in_idle;
  assign bus.done       = (state_q == DONE);
  assign bus.cfg_err    = err_q;

`ifdef A_RF_SEQ_STATS_EN
  always_ff @(posedge CLK or posedge RSTA) begin
    if (RSTA) begin
      stat_stall_cycles <= '0;
      stat_load_wait    <= '0;
    end else if (take_job) begin
      stat_stall_cycles <= '0;
      stat_load_wait    <= '0;
    end else begin
      if (in_read && !bus.mult_ready &&
          stat_stall_cycles != '1)
        stat_stall_cycles <=
          stat_stall_cycles + STAT_W'(1);
      if (in_load && !bus.a_valid &&
          stat_load_wait != '1)
        stat_load_wait <=
          stat_load_wait + STAT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_a_rf_sequencer.sv
// Self-checking bench for a_rf_sequencer with an RF model and
// a job-level reference of expected beats.
module tb_a_rf_sequencer;

  logic        CLK;
  logic        RSTA;
  logic [26:0] a_data;
  logic [26:0] rf [8];
  logic [2:0]  ra1;
  logic [53:0] a_mult;
  int          nchk;
  int          nerr;

  a_rf_seq_if bus ();

`ifdef A_RF_SEQ_STATS_EN
  logic [15:0] stat_stall_cycles;
  logic [15:0] stat_load_wait;
`endif

  a_rf_sequencer dut (
    .CLK  (CLK),
    .RSTA (RSTA),
    .bus  (bus)
`ifdef A_RF_SEQ_STATS_EN
    ,
    .stat_stall_cycles (stat_stall_cycles),
    .stat_load_wait    (stat_load_wait)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK or posedge RSTA) begin
    if (RSTA) begin
      for (int i = 0; i < 8; i++) rf[i] <= '0;
    end else if (bus.RF_load) begin
      for (int i = 7; i > 0; i--) rf[i] <= rf[i-1];
      rf[0] <= a_data;
    end
  end

  assign ra1    = bus.r_addr + 3'd1;
  assign a_mult = bus.MDRr ?
    {rf[ra1], rf[bus.r_addr]} :
    {27'd0, rf[bus.r_addr]};

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic run_job(input int len,
                         input int passes,
                         input bit mdr,
                         input bit seq,
                         input int stall_at,
                         input int rst_at);
    logic [26:0] w [8];
    logic [53:0] ed;
    int nb, total, k, cyc, beats;
    int bi, ea, st, lw, stall_left;
    bit stalling;
    nb    = mdr ? len / 2 : len;
    total = ((passes == 0) ? 1 : passes) * nb;
    for (int i = 0; i < 8; i++)
      w[i] = seq ? 27'(10 + i) :
                   27'($urandom);
    bus.cfg_len    = 4'(len);
    bus.cfg_passes = 8'(passes);
    bus.cfg_mdr    = mdr;
    bus.start      = 1'b1;
    @(negedge CLK);
    bus.start = 1'b0;
    #1;
    chk("load_busy", bus.busy, 1);
    chk("load_cea1", bus.CEA1, 0);
    chk("load_cea2", bus.CEA2, 0);
    k = 0; cyc = 0; lw = 0;
    while (k < len && cyc < 500) begin
      bus.a_valid = seq ? 1'b1 :
        ($urandom_range(0, 3) != 0);
      a_data = w[k];
      if (!bus.a_valid) lw++;
      #1;
      if (bus.RF_load) k++;
      cyc++;
      @(negedge CLK);
    end
    bus.a_valid = 1'b0;
    chk("load_words", k, len);
    beats = 0; cyc = 0; st = 0; stall_left = 5;
    while (beats < total && cyc < 2000) begin
      if (rst_at == beats) begin
        RSTA = 1'b1;
        #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_mv", bus.mult_valid, 0);
        chk("rst_raddr", bus.r_addr, 0);
        chk("rst_mdr", bus.MDRr, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_aready", bus.a_ready, 0);
`ifdef A_RF_SEQ_STATS_EN
        chk("rst_stall", stat_stall_cycles, 0);
        chk("rst_lwait", stat_load_wait, 0);
`endif
        return;
      end
      stalling = (beats == stall_at) &&
                 (stall_left > 0);
      bus.mult_ready = stalling ? 1'b0 :
        (seq ? 1'b1 : ($urandom_range(0, 3) != 0));
      #1;
      bi = beats % nb;
      ea = mdr ? len - 2 - 2 * bi : len - 1 - bi;
      ed = mdr ? {w[2*bi], w[2*bi+1]} :
                 {27'd0, w[bi]};
      if (stalling) begin
        stall_left--;
        chk("stall_addr", bus.r_addr, ea);
        chk("stall_valid", bus.mult_valid, 1);
      end
      if (!bus.mult_ready) begin
        st++;
      end else begin
        chk("beat_valid", bus.mult_valid, 1);
        chk("beat_addr", bus.r_addr, ea);
        chk("beat_data", a_mult, ed);
        beats++;
      end
      cyc++;
      @(negedge CLK);
    end
    chk("beat_count", beats, total);
    bus.mult_ready = 1'b0;
    bus.start      = 1'b1;
    #1;
    chk("done_pulse", bus.done, 1);
    chk("done_mv", bus.mult_valid, 0);
    @(negedge CLK);
    bus.start = 1'b0;
    #1;
    chk("idle_busy", bus.busy, 0);
    chk("idle_done", bus.done, 0);
`ifdef A_RF_SEQ_STATS_EN
    chk("stat_stall", stat_stall_cycles, st);
    chk("stat_lwait", stat_load_wait, lw);
`endif
  endtask

  task automatic err_case(input int len,
                          input bit mdr);
    bus.cfg_len    = 4'(len);
    bus.cfg_mdr    = mdr;
    bus.cfg_passes = 8'd1;
    bus.start      = 1'b1;
    @(negedge CLK);
    bus.start = 1'b0;
    #1;
    chk("err_pulse", bus.cfg_err, 1);
    chk("err_busy", bus.busy, 0);
    @(negedge CLK);
    #1;
    chk("err_clear", bus.cfg_err, 0);
    chk("err_busy2", bus.busy, 0);
  endtask

  initial begin
    nchk = 0;
    nerr = 0;
    RSTA = 1'b1;
    a_data = '0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.cfg_len = '0;
    bus.cfg_passes = '0;
    bus.cfg_mdr = 1'b0;
    bus.ext_cea1 = 1'b1;
    bus.ext_cea2 = 1'b0;
    bus.a_valid = 1'b0;
    bus.mult_ready = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    chk("rst0_busy", bus.busy, 0);
    chk("rst0_aready", bus.a_ready, 0);
    chk("rst0_mv", bus.mult_valid, 0);
    chk("rst0_raddr", bus.r_addr, 0);
    chk("rst0_done", bus.done, 0);
    chk("rst0_err", bus.cfg_err, 0);
    chk("rst0_mdr", bus.MDRr, 0);
    chk("rst0_load", bus.RF_load, 0);
    RSTA = 1'b0;
    #1;
    chk("idle_cea1", bus.CEA1, 1);
    chk("idle_cea2", bus.CEA2, 0);
    bus.ext_cea1 = 1'b0;
    bus.ext_cea2 = 1'b1;
    #1;
    chk("idle_cea1b", bus.CEA1, 0);
    chk("idle_cea2b", bus.CEA2, 1);
    bus.ext_cea1 = 1'b1;
    @(negedge CLK);

    run_job(4, 1, 1'b0, 1'b1, -1, -1);
    run_job(8, 3, 1'b1, 1'b1, -1, -1);
    err_case(5, 1'b1);
    err_case(0, 1'b0);
    err_case(9, 1'b0);
    run_job(6, 2, 1'b0, 1'b0, 3, -1);

    // abort in LOAD after 2 of 6 words
    bus.cfg_len = 4'd6;
    bus.cfg_passes = 8'd1;
    bus.cfg_mdr = 1'b0;
    bus.start = 1'b1;
    @(negedge CLK);
    bus.start = 1'b0;
    bus.a_valid = 1'b1;
    a_data = 27'h1234;
    @(negedge CLK);
    a_data = 27'h5678;
    @(negedge CLK);
    bus.abort = 1'b1;
    #1;
    chk("abort_aready", bus.a_ready, 0);
    chk("abort_load", bus.RF_load, 0);
    @(negedge CLK);
    bus.abort = 1'b0;
    bus.a_valid = 1'b0;
    #1;
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_aready2", bus.a_ready, 0);

    // abort beats start in IDLE
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge CLK);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    #1;
    chk("abst_busy", bus.busy, 0);
    chk("abst_err", bus.cfg_err, 0);
    @(negedge CLK);

    run_job(8, 0, 1'b0, 1'b0, 5, -1);
    run_job(4, 2, 1'b0, 1'b0, -1, 2);
    @(negedge CLK);
    RSTA = 1'b0;
    @(negedge CLK);

    for (int j = 0; j < 6; j++) begin
      bit m;
      int l;
      m = 1'($urandom_range(0, 1));
      l = m ? 2 * $urandom_range(1, 4) :
              $urandom_range(1, 8);
      run_job(l, $urandom_range(0, 3), m, 1'b0,
              $urandom_range(0, 8), -1);
    end

    $display("Result: errors=%0d of %0d checks",
             nerr, nchk);
    $finish;
  end

endmodule
